vec_deserializer: RTL and testbench
===================================

// Module: vec_deserializer
// PURPOSE
//  - Serial-to-parallel packer. Collects IDW-bit elements, one per accepted beat, into a packed
//    [DATA_NUM-1:0][IDW-1:0] vector.
//  - Sits in front of the tree-structure adder and produces the vector it reduces.
//  - Handshake: valid/ready on both sides. Supports short frames (i_last) with zero-fill and a
//    synchronous flush.
// PARAMETERS
//  IDW       10  element width (bits)
//  DATA_NUM  8   elements per vector; must be >= 2
//  CNT_W     localparam = $clog2(DATA_NUM+1), width of o_cnt
// PORTS
//  i_clk    in   1               clock
//  i_rst_n  in   1               asynchronous, active-low reset
//  i_flush  in   1               synchronous clear of partial/held vector
//  i_vld    in   1               input element valid
//  i_data   in   IDW             input element
//  i_last   in   1               element is last of frame (may close vector early)
//  o_rdy    out  1               ready to accept element
//  o_vld    out  1               packed vector valid
//  o_data   out  DATA_NUM*IDW    packed vector, element k at o_data[k]
//  o_cnt    out  CNT_W           number of real elements in o_data (1..DATA_NUM)
//  i_rdy    in   1               downstream ready
// BEHAVIOUR
//  - Reset: o_vld=0, o_data=0, o_cnt=0, o_rdy=1 one cycle after deassert; FSM=FILL, wr_idx=0.
//  - Accept = i_vld & o_rdy. Handoff = o_vld & i_rdy.
//  - FSM FILL:
//    - On accept, store i_data at o_data[wr_idx] and increment wr_idx.
//    - If wr_idx==DATA_NUM-1 or i_last: go to HOLD next cycle, assert o_vld, o_cnt=wr_idx+1.
//  - FSM HOLD:
//    - o_vld=1; o_data and o_cnt stable until handoff.
//    - o_rdy = i_rdy. Same-cycle handoff and accept loads the new element into slot 0, clears
//      slots 1..DATA_NUM-1, and returns to FILL with wr_idx=1 (or stays in HOLD if that element
//      closes the vector).
//    - Handoff without accept: go to FILL, wr_idx=0, clear o_data.
//  - Latency: o_vld rises on the cycle after the closing accept. Full throughput is
//    DATA_NUM beats per vector with no bubble while i_rdy=1.
//  - Zero-fill: slots at index >= o_cnt read 0 while o_vld=1, so the adder sum is exact for
//    short frames.
//  - i_last on a beat with wr_idx==DATA_NUM-1: a single close, no empty vector.
//  - i_vld with o_rdy=0: element not taken. Upstream must hold i_data and i_last stable.
//  - i_flush: highest priority over accept and handoff. Next cycle: FILL, wr_idx=0, o_vld=0,
//    o_data=0, o_cnt=0. A coincident input beat is dropped.
//  - Reset mid-frame discards the partial vector. No output glitch beyond async clear.
// CONFIGURATION
//  - Macro VEC_DESER_SUM_EN.
//  - Defined: adds port o_sum, out, IDW+$clog2(DATA_NUM) bits, unsigned.
//    - Running sum is registered, accumulated per accept, and valid with o_vld.
//    - Equals the sum of o_data[0..DATA_NUM-1].
//    - Cleared by reset, flush, and handoff. Seeded with i_data on the overlapped accept.
//  - Undefined: no o_sum port and no accumulator logic. All other behaviour identical.
// STRUCTURE
//  - Package vec_deser_pkg:
//    - typedef enum logic {ST_FILL, ST_HOLD} vec_deser_st_e
//    - function cnt_w(n) = $clog2(n+1)
//    - function sum_w(idw,n) = idw+$clog2(n)
//  - Sub-module vec_deser_ctrl holds FSM, wr_idx and o_rdy/o_vld. The top holds the data
//    slots and the optional accumulator.
//  - Intended pairing: o_vld/o_data feed the tree adder's i_vld/i_data directly.
// TESTING (IDW=10, DATA_NUM=8)
//  1. Full vector, i_rdy=1: beats 1..8 back-to-back -> o_vld one cycle after beat 8,
//     o_data={8,7,..,1}, o_cnt=8, o_sum=36 with SUM_EN.
//  2. Short frame: beats 0x3FF,0x3FF,0x3FF with i_last on the 3rd -> o_cnt=3,
//     o_data[2:0]=0x3FF, o_data[7:3]=0, o_sum=3069.
//  3. Backpressure: i_rdy=0 for 5 cycles after close -> o_rdy=0, o_data stable,
//     i_vld beats not taken. Then i_rdy=1 with i_vld=1, data=0x055 -> handoff plus new
//     vector slot0=0x055.
//  4. Continuous stream, i_rdy=1: 64 beats -> 8 vectors, one o_vld every 8 cycles, no lost
//     or duplicated element.
//  5. Flush after 4 accepts, beat coincident -> o_vld=0, o_cnt=0. Next 8 beats form a clean
//     vector from slot 0.
//  6. Async reset asserted in HOLD -> o_vld=0 and o_data=0 immediately. After release,
//     o_rdy=1 and FSM=FILL.

Source files
------------

// File: rtl/vec_deser_pkg.sv
// -----------------------------------------------------------------------------
// vec_deser_pkg
// Shared types and sizing helpers for the vec_deserializer block.
//   vec_deser_st_e : control FSM state (FILL collects elements, HOLD presents
//                    a closed vector until the downstream takes it)
//   cnt_w(n)       : width of a counter that must hold 0..n
//   sum_w(idw, n)  : width of an unsigned sum of n elements of idw bits
// -----------------------------------------------------------------------------
package vec_deser_pkg;

  typedef enum logic {
    ST_FILL,
    ST_HOLD
  } vec_deser_st_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int sum_w(input int idw, input int n);
    return idw + $clog2(n);
  endfunction

endpackage

// File: rtl/vec_deser_ctrl.sv
// -----------------------------------------------------------------------------
// vec_deser_ctrl
// Control path of the serial-to-parallel packer: FILL/HOLD FSM, write index,
// input ready and packed-vector valid/count. The data slots live in the top.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_flush         synchronous clear, wins over accept and handoff
//   i_vld, i_last   upstream element valid / last-of-frame marker
//   i_rdy           downstream ready
//   o_rdy           ready to accept an element
//   o_vld, o_cnt    packed vector valid and its number of real elements
//   o_wr_en         store the current element this cycle
//   o_wr_idx        slot the current element goes to
//   o_clr           zero all slots (and the running sum) this cycle
// -----------------------------------------------------------------------------
module vec_deser_ctrl
  import vec_deser_pkg::*;
#(
  parameter  int DATA_NUM = 8,
  localparam int CNT_W    = cnt_w(DATA_NUM),
  localparam int IDX_W    = $clog2(DATA_NUM)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic             i_last,
  input  logic             i_rdy,
  output logic             o_rdy,
  output logic             o_vld,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic             o_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_NUM - 1);

  vec_deser_st_e    r_state;
  logic [IDX_W-1:0] r_wr_idx;
  logic             w_acc;
  logic             w_handoff;
  logic             w_close;

  // In HOLD the block can take an element only in the cycle the held vector
  // leaves, so o_rdy follows the downstream ready there.
  assign o_rdy     = (r_state == ST_FILL) | i_rdy;
  assign w_acc     = i_vld & o_rdy;
  assign w_handoff = o_vld & i_rdy;

  // An accept in HOLD always coincides with a handoff: that element starts
  // the next vector in slot 0.
  assign o_wr_idx  = (r_state == ST_HOLD) ? '0 : r_wr_idx;
  assign o_wr_en   = w_acc & ~i_flush;
  assign o_clr     = i_flush | w_handoff;

  // Last slot filled or frame ended: one close either way, never an empty
  // vector.
  assign w_close   = i_last | (o_wr_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_FILL;
      r_wr_idx <= '0;
      o_vld    <= 1'b0;
      o_cnt    <= '0;
    end else if (i_flush) begin
      r_state  <= ST_FILL;
      r_wr_idx <= '0;
      o_vld    <= 1'b0;
      o_cnt    <= '0;
    end else if (o_wr_en && w_close) begin
      r_state  <= ST_HOLD;
      r_wr_idx <= '0;
      o_vld    <= 1'b1;
      o_cnt    <= CNT_W'(o_wr_idx) + CNT_W'(1);
    end else if (o_wr_en) begin
      r_state  <= ST_FILL;
      r_wr_idx <= o_wr_idx + 1'b1;
      o_vld    <= 1'b0;
      o_cnt    <= '0;
    end else if (w_handoff) begin
      r_state  <= ST_FILL;
      r_wr_idx <= '0;
      o_vld    <= 1'b0;
      o_cnt    <= '0;
    end
  end

endmodule

// File: rtl/vec_deserializer.sv
// -----------------------------------------------------------------------------
// vec_deserializer
// Serial-to-parallel packer in front of the tree adder. Collects IDW-bit
// elements, one per accepted beat, into a packed [DATA_NUM-1:0][IDW-1:0]
// vector. Short frames (i_last) close early; unused slots read zero so the
// adder's sum stays exact.
// Optional feature, macro VEC_DESER_SUM_EN: adds o_sum, a registered running
// sum of the collected elements, valid together with o_vld.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_flush         synchronous clear of partial/held vector
//   i_vld, i_data   input element handshake and payload
//   i_last          element is the last of its frame
//   o_rdy           ready to accept an element
//   o_vld, o_data   packed vector handshake and payload, element k at o_data[k]
//   o_cnt           number of real elements in o_data (1..DATA_NUM)
//   o_sum           (VEC_DESER_SUM_EN only) sum of o_data elements
//   i_rdy           downstream ready
// -----------------------------------------------------------------------------
module vec_deserializer
  import vec_deser_pkg::*;
#(
  parameter  int IDW      = 10,
  parameter  int DATA_NUM = 8,
  localparam int CNT_W    = cnt_w(DATA_NUM),
  localparam int IDX_W    = $clog2(DATA_NUM)
`ifdef VEC_DESER_SUM_EN
  ,
  localparam int SUM_W    = sum_w(IDW, DATA_NUM)
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_vld,
  input  logic [IDW-1:0]               i_data,
  input  logic                         i_last,
  output logic                         o_rdy,
  output logic                         o_vld,
  output logic [DATA_NUM-1:0][IDW-1:0] o_data,
  output logic [CNT_W-1:0]             o_cnt,
`ifdef VEC_DESER_SUM_EN
  output logic [SUM_W-1:0]             o_sum,
`endif
  input  logic                         i_rdy
);

  logic                         w_wr_en;
  logic                         w_clr;
  logic [IDX_W-1:0]             w_wr_idx;
  logic [DATA_NUM-1:0][IDW-1:0] w_data_nxt;

  vec_deser_ctrl #(
    .DATA_NUM (DATA_NUM)
  ) u_ctrl (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (i_flush),
    .i_vld    (i_vld),
    .i_last   (i_last),
    .i_rdy    (i_rdy),
    .o_rdy    (o_rdy),
    .o_vld    (o_vld),
    .o_cnt    (o_cnt),
    .o_wr_en  (w_wr_en),
    .o_wr_idx (w_wr_idx),
    .o_clr    (w_clr)
  );

  // Clearing on every handoff is what provides the zero-fill: slots beyond
  // the write index of a new vector are already zero when it closes.
  // NOTE: the combinational next-state block assigns a full default first,
  // so no path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    w_data_nxt = w_clr ? '0 : o_data;
    if (w_wr_en) begin
      w_data_nxt[w_wr_idx] = i_data;
    end
  end

  // NOTE: the slots are a flop bank, not a RAM, and are reset because the
  // output vector must read zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else begin
      o_data <= w_data_nxt;
    end
  end

`ifdef VEC_DESER_SUM_EN
  logic [SUM_W-1:0] w_sum_nxt;

  // Mirrors the slot update: cleared with the slots, seeded by the element
  // taken in a handoff cycle, accumulated on every stored element.
  always_comb begin
    w_sum_nxt = w_clr ? '0 : o_sum;
    if (w_wr_en) begin
      w_sum_nxt = w_sum_nxt + SUM_W'(i_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum <= '0;
    end else begin
      o_sum <= w_sum_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vec_deserializer.sv
// -----------------------------------------------------------------------------
// tb_vec_deserializer
// Directed scenarios plus a randomized phase for vec_deserializer
// (IDW=10, DATA_NUM=8). A frame-level reference model records accepted
// elements, closes frames at DATA_NUM elements or i_last, and queues the
// expected zero-padded vector, its count and its sum until handoff.
// o_sum is checked only when VEC_DESER_SUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_vec_deserializer;

  localparam int IDW      = 10;
  localparam int DATA_NUM = 8;
  localparam int CNT_W    = $clog2(DATA_NUM + 1);
`ifdef VEC_DESER_SUM_EN
  localparam int SUM_W    = IDW + $clog2(DATA_NUM);
`endif

  typedef logic [DATA_NUM-1:0][IDW-1:0] vec_t;
  typedef logic [IDW-1:0]               elem_t;
  typedef struct {
    vec_t vec;
    int   cnt;
    int   sum;
  } exp_t;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_flush;
  logic             i_vld;
  elem_t            i_data;
  logic             i_last;
  logic             i_rdy;
  logic             o_rdy;
  logic             o_vld;
  vec_t             o_data;
  logic [CNT_W-1:0] o_cnt;
`ifdef VEC_DESER_SUM_EN
  logic [SUM_W-1:0] o_sum;
`endif

  int n_chk  = 0;
  int n_err  = 0;
  int n_hand = 0;
  int cyc    = 0;

  elem_t frame[$];
  exp_t  exp_q[$];

  vec_deserializer #(
    .IDW      (IDW),
    .DATA_NUM (DATA_NUM)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_vld   (i_vld),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_rdy   (o_rdy),
    .o_vld   (o_vld),
    .o_data  (o_data),
    .o_cnt   (o_cnt),
`ifdef VEC_DESER_SUM_EN
    .o_sum   (o_sum),
`endif
    .i_rdy   (i_rdy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Offers one element and waits until it is taken.
  task automatic send(input elem_t d, input logic last);
    bit ok;
    ok     = 1'b0;
    i_vld  = 1'b1;
    i_data = d;
    i_last = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge i_clk);
      ok = o_rdy;
      tick();
    end
    i_vld  = 1'b0;
    i_last = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  function automatic vec_t pack(input elem_t q[$]);
    vec_t v;
    v = '0;
    foreach (q[k]) v[k] = q[k];
    return v;
  endfunction

  function automatic int total(input elem_t q[$]);
    int s;
    s = 0;
    foreach (q[k]) s += int'(q[k]);
    return s;
  endfunction

  // Frame-level reference model, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      frame.delete();
      exp_q.delete();
    end else begin
      check("mon_vld", o_vld, exp_q.size() != 0);
      check("mon_rdy", o_rdy, (exp_q.size() == 0) || i_rdy);
      if (exp_q.size() != 0) begin
        check("mon_held_data", o_data, exp_q[0].vec);
        check("mon_held_cnt", o_cnt, exp_q[0].cnt);
`ifdef VEC_DESER_SUM_EN
        check("mon_held_sum", o_sum, exp_q[0].sum);
`endif
      end else begin
        check("mon_partial_data", o_data, pack(frame));
`ifdef VEC_DESER_SUM_EN
        check("mon_partial_sum", o_sum, total(frame));
`endif
      end

      if (i_flush) begin
        frame.delete();
        exp_q.delete();
      end else begin
        if (o_vld && i_rdy && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_hand++;
        end
        if (i_vld && o_rdy) begin
          frame.push_back(i_data);
          if (frame.size() == DATA_NUM || i_last) begin
            exp_t e;
            e.vec = pack(frame);
            e.cnt = frame.size();
            e.sum = total(frame);
            exp_q.push_back(e);
            frame.delete();
          end
        end
      end
    end
  end

  initial begin
    vec_t ev;
    int   c0;
    int   h0;
    bit   took;

    i_rst_n = 1'b1;
    i_flush = 1'b0;
    i_vld   = 1'b0;
    i_last  = 1'b0;
    i_rdy   = 1'b1;
    i_data  = '0;

    // Reset state
    #1 i_rst_n = 1'b0;
    #2;
    check("rst_vld", o_vld, 0);
    check("rst_data", o_data, 0);
    check("rst_cnt", o_cnt, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_rdy", o_rdy, 1);
    tick();

    // 1. Full vector 1..8 with downstream ready
    for (int k = 1; k <= DATA_NUM; k++) send(elem_t'(k), 1'b0);
    for (int k = 0; k < DATA_NUM; k++) ev[k] = elem_t'(k + 1);
    @(negedge i_clk);
    check("full_vld", o_vld, 1);
    check("full_data", o_data, ev);
    check("full_cnt", o_cnt, 8);
`ifdef VEC_DESER_SUM_EN
    check("full_sum", o_sum, 36);
`endif
    tick();
    @(negedge i_clk);
    check("full_handoff_vld", o_vld, 0);
    tick();

    // 2. Short frame of three max-value elements, downstream stalled
    i_rdy = 1'b0;
    send(10'h3FF, 1'b0);
    send(10'h3FF, 1'b0);
    send(10'h3FF, 1'b1);
    ev = '0;
    for (int k = 0; k < 3; k++) ev[k] = 10'h3FF;
    @(negedge i_clk);
    check("short_vld", o_vld, 1);
    check("short_cnt", o_cnt, 3);
    check("short_data", o_data, ev);
`ifdef VEC_DESER_SUM_EN
    check("short_sum", o_sum, 3069);
`endif
    tick();

    // 3. Backpressure, then overlapped handoff and accept
    i_vld  = 1'b1;
    i_data = 10'h123;
    i_last = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      check("bp_rdy", o_rdy, 0);
      check("bp_vld", o_vld, 1);
      check("bp_data_stable", o_data, ev);
      tick();
    end
    i_rdy  = 1'b1;
    i_data = 10'h055;
    @(negedge i_clk);
    check("bp_release_rdy", o_rdy, 1);
    tick();
    i_vld = 1'b0;
    ev    = '0;
    ev[0] = 10'h055;
    @(negedge i_clk);
    check("overlap_vld", o_vld, 0);
    check("overlap_data", o_data, ev);
`ifdef VEC_DESER_SUM_EN
    check("overlap_sum", o_sum, 'h55);
`endif
    tick();
    repeat (DATA_NUM - 1) send(elem_t'($urandom), 1'b0);
    tick();
    tick();

    // 4. Continuous stream: 64 beats, no bubble, 8 vectors
    c0 = cyc;
    h0 = n_hand;
    repeat (64) send(elem_t'($urandom), 1'b0);
    check("stream_cycles", cyc - c0, 64);
    tick();
    check("stream_vectors", n_hand - h0, 8);
    check("stream_drained", exp_q.size() + frame.size(), 0);

    // 5. Flush after four accepts, coincident beat dropped
    repeat (4) send(elem_t'($urandom), 1'b0);
    i_vld   = 1'b1;
    i_data  = 10'h2AA;
    i_flush = 1'b1;
    @(negedge i_clk);
    tick();
    i_flush = 1'b0;
    i_vld   = 1'b0;
    @(negedge i_clk);
    check("flush_vld", o_vld, 0);
    check("flush_cnt", o_cnt, 0);
    check("flush_data", o_data, 0);
`ifdef VEC_DESER_SUM_EN
    check("flush_sum", o_sum, 0);
`endif
    tick();
    for (int k = 0; k < DATA_NUM; k++) begin
      send(elem_t'(10'h100 + k), 1'b0);
      ev[k] = elem_t'(10'h100 + k);
    end
    @(negedge i_clk);
    check("post_flush_vld", o_vld, 1);
    check("post_flush_cnt", o_cnt, 8);
    check("post_flush_data", o_data, ev);
    tick();

    // 6. Asynchronous reset while holding a vector
    i_rdy = 1'b0;
    send(10'h0AB, 1'b0);
    send(10'h0CD, 1'b1);
    @(negedge i_clk);
    check("hold_before_rst_vld", o_vld, 1);
    check("hold_before_rst_cnt", o_cnt, 2);
    tick();
    #1 i_rst_n = 1'b0;
    #1;
    check("async_rst_vld", o_vld, 0);
    check("async_rst_data", o_data, 0);
    check("async_rst_cnt", o_cnt, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_rdy_fill", o_rdy, 1);
    check("post_rst_vld", o_vld, 0);
    tick();
    i_rdy = 1'b1;
    for (int k = 0; k < DATA_NUM; k++) send(elem_t'($urandom), 1'b0);
    @(negedge i_clk);
    check("post_rst_full_cnt", o_cnt, 8);
    tick();

    // 7. Randomized traffic: stalls, short frames, occasional flush
    for (int c = 0; c < 800; c++) begin
      @(negedge i_clk);
      took = i_vld && o_rdy;
      tick();
      if (!i_vld || took) begin
        i_vld  = ($urandom_range(0, 9) < 7);
        i_data = elem_t'($urandom);
        i_last = ($urandom_range(0, 9) < 2);
      end
      i_rdy   = ($urandom_range(0, 9) < 6);
      i_flush = ($urandom_range(0, 49) == 0);
    end
    i_vld   = 1'b0;
    i_last  = 1'b0;
    i_flush = 1'b0;
    i_rdy   = 1'b1;
    repeat (3) tick();
    check("random_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
